// File: rtl/mult_op_sequencer.sv
// -----------------------------------------------------------------------------
// mult_op_sequencer
//
// Purpose:
//   Upstream operand feeder for booth_mult. Signed operand pairs are buffered
//   in a small FIFO. They are issued one at a time over the multiplier's level
//   en/done handshake. Each product is returned on a single-entry valid/ready
//   output slot. Products leave in the same order as their operand pairs arrived.
//
// Parameters:
//   WIDTH  operand width; products are 2*WIDTH bits, two's complement
//   DEPTH  operand FIFO entries (power of two, >= 2)
//   AW     log2(DEPTH), FIFO pointer width
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous reset, active-high (asserted when rst_n == 1)
//   in_valid_i    operand pair offered
//   in_ready_o    FIFO can accept (not full)
//   in_a_i/in_b_i signed operands
//   mul_en_o      booth_mult en, held high for the whole operation
//   mul_a_o/b_o   booth_mult operands, frozen while mul_en_o is high
//   mul_done_i    booth_mult done
//   mul_m_i       booth_mult product
//   out_valid_o   product available
//   out_ready_i   consumer accepts product
//   out_m_o       signed product
//   out_tag_o     push-order tag of the product (only with MULT_SEQ_TAG_EN)
//   level_o       FIFO occupancy, 0..DEPTH
//   busy_o        sequencer is not idle
//
// Configuration:
//   MULT_SEQ_TAG_EN  when defined, every pushed pair is tagged with a wrapping
//                    AW+1 bit push counter, and the tag travels with its
//                    product to out_tag_o.
// -----------------------------------------------------------------------------
module mult_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   in_a_i,
    input  logic [WIDTH-1:0]   in_b_i,
    output logic               mul_en_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    input  logic               mul_done_i,
    input  logic [2*WIDTH-1:0] mul_m_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] out_m_o,
`ifdef MULT_SEQ_TAG_EN
    output logic [AW:0]        out_tag_o,
`endif
    output logic [AW:0]        level_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;

    logic [WIDTH-1:0]   mem_a [DEPTH];
    logic [WIDTH-1:0]   mem_b [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;

    logic               mul_en_q, mul_en_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] out_m_q, out_m_d;

`ifdef MULT_SEQ_TAG_EN
    logic [AW:0]        mem_tag [DEPTH];
    logic [AW:0]        tag_cnt_q, tag_cnt_d;
    logic [AW:0]        run_tag_q, run_tag_d;
    logic [AW:0]        out_tag_q, out_tag_d;
`endif

    logic               push;
    logic               pop;
    logic               slot_free;

    // The FIFO accepts whenever it is not full. A pop never frees space for a
    // push in the same cycle, because the FIFO has no bypass.
    assign in_ready_o = (level_q != (AW+1)'(DEPTH));
    assign push       = in_valid_i && in_ready_o;

    // The output slot can take a new product when it is empty, or when it is
    // being drained in this cycle.
    assign slot_free  = !out_valid_q || out_ready_i;

    // FIFO pointer and occupancy bookkeeping. The pointers are AW bits wide,
    // so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef MULT_SEQ_TAG_EN
        tag_cnt_d = tag_cnt_q + (AW+1)'(push);
`endif
    end

    // FIFO storage. It is not reset: entries are only ever read after they
    // have been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= in_a_i;
            mem_b[wr_ptr_q] <= in_b_i;
`ifdef MULT_SEQ_TAG_EN
            mem_tag[wr_ptr_q] <= tag_cnt_q;
`endif
        end
    end

    // Next state and registered outputs. IDLE issues only when the output slot
    // can absorb the eventual product, so a held product is never overwritten.
    // GAP guarantees en is low for at least one cycle between operations.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mul_en_d    = mul_en_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_m_d     = out_m_q;
`ifdef MULT_SEQ_TAG_EN
        run_tag_d   = run_tag_q;
        out_tag_d   = out_tag_q;
`endif
        case (state_q)
            IDLE: begin
                mul_en_d = 1'b0;
                if ((level_q != '0) && slot_free) begin
                    pop      = 1'b1;
                    mul_a_d  = mem_a[rd_ptr_q];
                    mul_b_d  = mem_b[rd_ptr_q];
                    mul_en_d = 1'b1;
`ifdef MULT_SEQ_TAG_EN
                    run_tag_d = mem_tag[rd_ptr_q];
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                mul_en_d = 1'b1;
                if (mul_done_i) begin
                    out_m_d     = mul_m_i;
                    out_valid_d = 1'b1;
                    mul_en_d    = 1'b0;
`ifdef MULT_SEQ_TAG_EN
                    out_tag_d   = run_tag_q;
`endif
                    state_d     = GAP;
                end
            end
            GAP: begin
                mul_en_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mul_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // All control and output registers. A reset drops mul_en immediately and
    // discards queued pairs and the held product.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
`ifdef MULT_SEQ_TAG_EN
            tag_cnt_q   <= '0;
            run_tag_q   <= '0;
            out_tag_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_valid_q <= out_valid_d;
            out_m_q     <= out_m_d;
`ifdef MULT_SEQ_TAG_EN
            tag_cnt_q   <= tag_cnt_d;
            run_tag_q   <= run_tag_d;
            out_tag_q   <= out_tag_d;
`endif
        end
    end

    assign mul_en_o    = mul_en_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign out_valid_o = out_valid_q;
    assign out_m_o     = out_m_q;
    assign level_o     = level_q;
    assign busy_o      = (state_q != IDLE);
`ifdef MULT_SEQ_TAG_EN
    assign out_tag_o   = out_tag_q;
`endif

endmodule
